// File: rtl/noc_defs.sv
// rtl/noc_defs.sv - flit type and input-port FSM encodings shared by router stages
package noc_defs;

  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flitType_e;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WAIT_GRANT = 2'b01,
    TRANSFER   = 2'b10
  } ipcState_e;

  function automatic logic opensPacket(flitType_e t);
    return (t == FLIT_HEAD) || (t == FLIT_HEADTAIL);
  endfunction

  function automatic logic closesPacket(flitType_e t);
    return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// rtl/flit_fifo.sv - power-of-two flit buffer with combinational head read
module flit_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic             doWrite;
  logic             doRead;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign doRead  = rdEn && !empty;
  // A pop frees the slot this edge, so a full buffer may still take a write.
  assign doWrite = wrEn && (!full || doRead);
  assign rdData  = mem[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead)  rdPtr <= rdPtr + 1'b1;
      if (doWrite && !doRead)      count <= count + 1'b1;
      else if (doRead && !doWrite) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/input_port_controller.sv
// rtl/input_port_controller.sv - router input port: flit buffer, route latch and switch request FSM
module input_port_controller
  import noc_defs::*;
#(
  parameter int N             = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int PhitPerFlit   = 2,
  parameter int REQUEST_WIDTH = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PhitPerFlit*DATA_WIDTH-1:0] in_flit,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [PhitPerFlit*DATA_WIDTH-1:0] head_flit,
  input  logic [REQUEST_WIDTH-1:0]      route_req_msg,
  output logic                          sw_req,
  output logic [REQUEST_WIDTH-1:0]      sw_port,
  input  logic                          sw_grant,
  output logic [PhitPerFlit*DATA_WIDTH-1:0] out_flit,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int FLIT_W = PhitPerFlit * DATA_WIDTH;
  localparam int DEST_W = (N > 1) ? $clog2(N) : 1;

  ipcState_e        state;
  ipcState_e        nextState;
  flitType_e        headType;
  logic             readyReg;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             pop;
  logic             latchPort;
  logic [DEST_W-1:0] unusedHeadDest;

  flit_fifo #(
    .WIDTH(FLIT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wrEn  (in_valid && in_ready),
    .wrData(in_flit),
    .rdEn  (pop),
    .rdData(head_flit),
    .empty (fifoEmpty),
    .full  (fifoFull)
  );

  // Destination bits are resolved by the external route decoder from head_flit.
  assign unusedHeadDest = head_flit[DEST_W-1:0];
  assign headType       = flitType_e'(head_flit[FLIT_W-1 -: 2]);
  assign in_ready       = readyReg && !fifoFull;
  assign out_flit       = head_flit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sw_port  <= '0;
      readyReg <= 1'b0;
    end else begin
      state    <= nextState;
      readyReg <= 1'b1;
      if (latchPort) sw_port <= route_req_msg;
    end
  end

  always_comb begin
    nextState = state;
    pop       = 1'b0;
    latchPort = 1'b0;
    sw_req    = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          if (opensPacket(headType)) begin
            nextState = WAIT_GRANT;
            latchPort = 1'b1;
          end else begin
            pop = 1'b1;  // stray BODY/TAIL with no open packet
          end
        end
      end
      WAIT_GRANT: begin
        sw_req = 1'b1;
        if (sw_grant) nextState = TRANSFER;
      end
      TRANSFER: begin
        sw_req    = 1'b1;
        out_valid = !fifoEmpty;
        if (out_valid && out_ready) begin
          pop = 1'b1;
          if (closesPacket(headType)) nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_input_port_controller.sv
// tb/tb_input_port_controller.sv - scoreboard bench for input_port_controller
module tb_input_port_controller;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] head_flit;
  logic [1:0]  route_req_msg;
  logic        sw_req;
  logic [1:0]  sw_port;
  logic        sw_grant;
  logic [15:0] out_flit;
  logic        out_valid;
  logic        out_ready;

  int          checkCnt = 0;
  int          passCnt = 0;
  logic [15:0] expQ[$];
  logic        modelInPkt = 1'b0;

  input_port_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_flit      (in_flit),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .head_flit    (head_flit),
    .route_req_msg(route_req_msg),
    .sw_req       (sw_req),
    .sw_port      (sw_port),
    .sw_grant     (sw_grant),
    .out_flit     (out_flit),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  // Route decoder model: destination sits in the low bits of the head flit.
  assign route_req_msg = head_flit[1:0];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scoreboard();
    logic [15:0] expFlit;
    logic [1:0]  ty;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expQ.delete();
        modelInPkt = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          checkCnt++;
          if (expQ.size() == 0) begin
            $display("FAIL sb_unexpected out_flit=%h but no flit expected", out_flit);
          end else begin
            expFlit = expQ.pop_front();
            if (out_flit !== expFlit)
              $display("FAIL sb_order out_flit=%h required %h", out_flit, expFlit);
            else passCnt++;
          end
        end
        if (in_valid && in_ready) begin
          ty = in_flit[15:14];
          if (modelInPkt) begin
            expQ.push_back(in_flit);
            if (ty[1]) modelInPkt = 1'b0;
          end else if (ty[0]) begin
            expQ.push_back(in_flit);
            modelInPkt = (ty == 2'b01);
          end
        end
      end
    end
  endtask

  task automatic sendFlit(input logic [15:0] f);
    int n;
    n = 0;
    in_flit  = f;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checkCnt++;
      $display("FAIL send_timeout flit=%h in_ready=%b required 1", f, in_ready);
    end else begin
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checkCnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b required 0", in_ready); else passCnt++;
    checkCnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b required 0", out_valid); else passCnt++;
    checkCnt++; if (sw_req !== 1'b0) $display("FAIL rst_sw_req got %b required 0", sw_req); else passCnt++;
    checkCnt++; if (sw_port !== 2'b00) $display("FAIL rst_sw_port got %b required 00", sw_port); else passCnt++;
    rst_n = 1'b1;
    #1;
    checkCnt++; if (in_ready !== 1'b0) $display("FAIL rst_ready_early got %b required 0", in_ready); else passCnt++;
    step();
    checkCnt++; if (in_ready !== 1'b1) $display("FAIL rst_ready_rise got %b required 1", in_ready); else passCnt++;
  endtask

  task automatic test_headtail();
    sw_grant  = 1'b1;
    out_ready = 1'b1;
    in_flit   = 16'hC0A2;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    checkCnt++; if (sw_req !== 1'b0) $display("FAIL ht_req_t0 got %b required 0", sw_req); else passCnt++;
    step();
    checkCnt++; if (sw_req !== 1'b1) $display("FAIL ht_req_t1 got %b required 1", sw_req); else passCnt++;
    checkCnt++; if (sw_port !== 2'b10) $display("FAIL ht_port got %b required 10", sw_port); else passCnt++;
    checkCnt++; if (out_valid !== 1'b0) $display("FAIL ht_valid_t1 got %b required 0", out_valid); else passCnt++;
    step();
    checkCnt++; if (out_valid !== 1'b1) $display("FAIL ht_valid_t2 got %b required 1", out_valid); else passCnt++;
    checkCnt++; if (out_flit !== 16'hC0A2) $display("FAIL ht_flit got %h required c0a2", out_flit); else passCnt++;
    step();
    checkCnt++; if (sw_req !== 1'b0) $display("FAIL ht_req_after got %b required 0", sw_req); else passCnt++;
    checkCnt++; if (out_valid !== 1'b0) $display("FAIL ht_valid_after got %b required 0", out_valid); else passCnt++;
    checkCnt++; if (expQ.size() != 0) $display("FAIL ht_drain got %0d pending required 0", expQ.size()); else passCnt++;
  endtask

  task automatic test_grant_delay();
    logic [15:0] pkt [4];
    int reqCycles, reqFirst, reqLast, validCycles;
    pkt[0] = 16'h4001; pkt[1] = 16'h0111; pkt[2] = 16'h0222; pkt[3] = 16'h8333;
    reqCycles = 0; reqFirst = -1; reqLast = -1; validCycles = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 4);
      in_flit  = pkt[c % 4];
      sw_grant = (c >= 5);
      step();
      if (sw_req) begin
        reqCycles++;
        if (reqFirst < 0) reqFirst = c + 1;
        reqLast = c + 1;
      end
      if (out_valid) validCycles++;
    end
    in_valid = 1'b0;
    sw_grant = 1'b0;
    checkCnt++; if (reqFirst != 2) $display("FAIL gd_req_first got edge %0d required 2", reqFirst); else passCnt++;
    checkCnt++; if (reqLast != 9) $display("FAIL gd_req_last got edge %0d required 9", reqLast); else passCnt++;
    checkCnt++; if (reqCycles != 8) $display("FAIL gd_req_cycles got %0d required 8", reqCycles); else passCnt++;
    checkCnt++; if (validCycles != 4) $display("FAIL gd_valid_cycles got %0d required 4", validCycles); else passCnt++;
    checkCnt++; if (expQ.size() != 0) $display("FAIL gd_drain got %0d pending required 0", expQ.size()); else passCnt++;
  endtask

  task automatic test_full();
    logic [15:0] pkt [6];
    int acc;
    logic a;
    pkt[0] = 16'h4003; pkt[1] = 16'h0A10; pkt[2] = 16'h0A20;
    pkt[3] = 16'h0A30; pkt[4] = 16'h0A40; pkt[5] = 16'h8ACE;
    acc = 0;
    sw_grant  = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_flit  = pkt[acc];
      in_valid = 1'b1;
      a = in_ready;
      step();
      if (a) acc++;
    end
    in_valid = 1'b0;
    checkCnt++; if (acc != 4) $display("FAIL full_accepted got %0d required 4", acc); else passCnt++;
    checkCnt++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b required 0", in_ready); else passCnt++;
    checkCnt++; if (out_valid !== 1'b1) $display("FAIL full_out_valid got %b required 1", out_valid); else passCnt++;
    out_ready = 1'b1;
    step();
    checkCnt++; if (in_ready !== 1'b1) $display("FAIL full_after_pop got %b required 1", in_ready); else passCnt++;
    in_flit  = pkt[4];
    in_valid = 1'b1;
    step();
    checkCnt++; if (in_ready !== 1'b1) $display("FAIL full_pushpop got %b required 1", in_ready); else passCnt++;
    out_ready = 1'b0;
    in_flit   = pkt[5];
    step();
    in_valid = 1'b0;
    checkCnt++; if (in_ready !== 1'b0) $display("FAIL full_refill got %b required 0", in_ready); else passCnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (expQ.size() != 0 || sw_req); i++) step();
    checkCnt++; if (expQ.size() != 0) $display("FAIL full_drain got %0d pending required 0", expQ.size()); else passCnt++;
    checkCnt++; if (sw_req !== 1'b0) $display("FAIL full_req_end got %b required 0", sw_req); else passCnt++;
  endtask

  task automatic test_stray();
    int seenValid, seenReq;
    seenValid = 0; seenReq = 0;
    sw_grant  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 2);
      in_flit  = (c == 0) ? 16'h0123 : 16'h8456;
      step();
      if (out_valid) seenValid++;
      if (sw_req) seenReq++;
    end
    in_valid = 1'b0;
    checkCnt++; if (seenValid != 0) $display("FAIL stray_valid got %0d cycles required 0", seenValid); else passCnt++;
    checkCnt++; if (seenReq != 0) $display("FAIL stray_req got %0d cycles required 0", seenReq); else passCnt++;
    sendFlit(16'hC001);
    for (int i = 0; i < 30 && (expQ.size() != 0 || sw_req); i++) step();
    checkCnt++; if (expQ.size() != 0) $display("FAIL stray_next got %0d pending required 0", expQ.size()); else passCnt++;
    checkCnt++; if (sw_port !== 2'b01) $display("FAIL stray_port got %b required 01", sw_port); else passCnt++;
  endtask

  task automatic test_reset_mid();
    sw_grant  = 1'b1;
    out_ready = 1'b0;
    sendFlit(16'h4002);
    sendFlit(16'h0F0F);
    rst_n = 1'b0;
    #1;
    checkCnt++; if (sw_req !== 1'b0) $display("FAIL mid_sw_req got %b required 0", sw_req); else passCnt++;
    checkCnt++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %b required 0", out_valid); else passCnt++;
    checkCnt++; if (in_ready !== 1'b0) $display("FAIL mid_in_ready got %b required 0", in_ready); else passCnt++;
    checkCnt++; if (sw_port !== 2'b00) $display("FAIL mid_sw_port got %b required 00", sw_port); else passCnt++;
    step();
    rst_n = 1'b1;
    step();
    checkCnt++; if (in_ready !== 1'b1) $display("FAIL mid_ready_back got %b required 1", in_ready); else passCnt++;
    out_ready = 1'b1;
    sendFlit(16'h4003);
    sendFlit(16'h8C03);
    for (int i = 0; i < 30 && (expQ.size() != 0 || sw_req); i++) step();
    checkCnt++; if (expQ.size() != 0) $display("FAIL mid_fresh got %0d pending required 0", expQ.size()); else passCnt++;
    checkCnt++; if (sw_port !== 2'b11) $display("FAIL mid_fresh_port got %b required 11", sw_port); else passCnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] pkts [5];
    logic [1:0]  ports [5];
    int k;
    pkts[0] = 16'h4001; pkts[1] = 16'h0A02; pkts[2] = 16'h8A03;
    pkts[3] = 16'h4003; pkts[4] = 16'h8B00;
    ports[0] = 2'b01; ports[1] = 2'b01; ports[2] = 2'b01;
    ports[3] = 2'b11; ports[4] = 2'b11;
    k = 0;
    sw_grant  = 1'b1;
    out_ready = 1'b1;
    fork
      begin
        for (int j = 0; j < 5; j++) sendFlit(pkts[j]);
      end
      begin
        for (int i = 0; i < 60 && k < 5; i++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            checkCnt++;
            if (sw_port !== ports[k])
              $display("FAIL b2b_port flit %0d sw_port=%b required %b", k, sw_port, ports[k]);
            else passCnt++;
            k++;
          end
        end
      end
    join
    step();
    checkCnt++; if (k != 5) $display("FAIL b2b_count got %0d flits required 5", k); else passCnt++;
    checkCnt++; if (expQ.size() != 0) $display("FAIL b2b_drain got %0d pending required 0", expQ.size()); else passCnt++;
    checkCnt++; if (sw_req !== 1'b0) $display("FAIL b2b_req_end got %b required 0", sw_req); else passCnt++;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_flit   = '0;
    in_valid  = 1'b0;
    sw_grant  = 1'b0;
    out_ready = 1'b0;
    fork
      scoreboard();
    join_none
    test_reset();
    test_headtail();
    test_grant_delay();
    test_full();
    test_stray();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/input_port_controller.md
INPUT_PORT_CONTROLLER -- requirements
Module: input_port_controller

Interface
REQ-001 SHALL have parameter N, default 4: number of network nodes.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: phit width in bits.
REQ-003 SHALL have parameter PhitPerFlit, default 2: phits per flit; FLIT_W = PhitPerFlit*DATA_WIDTH.
REQ-004 SHALL have parameter REQUEST_WIDTH, default 2: width of the output-port request code.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: flit buffer depth, power of two, at least 2.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 in_flit  input  FLIT_W  flit from the upstream link.
REQ-009 in_valid / in_ready  input / output  1 each  upstream handshake; a transfer occurs when both are high at a clock edge.
REQ-010 head_flit  output  FLIT_W  flit at the FIFO head, driven to the route decoder.
REQ-011 route_req_msg  input  REQUEST_WIDTH  route decoder result for head_flit; combinational, same cycle.
REQ-012 sw_req / sw_port  output  1 / REQUEST_WIDTH  switch-allocator request and the latched output port.
REQ-013 sw_grant  input  1  allocator grant for sw_req.
REQ-014 out_flit / out_valid / out_ready  output / output / input  FLIT_W / 1 / 1  flit stream to the crossbar.

Function
REQ-015 Flit type SHALL be in_flit[FLIT_W-1:FLIT_W-2]: 01 = HEAD, 00 = BODY, 10 = TAIL, 11 = HEADTAIL (single-flit packet); the destination occupies the low $clog2(N) bits of head flits.
REQ-016 The FIFO SHALL accept a flit when in_valid && in_ready, with in_ready = !full.
REQ-017 in_ready SHALL depend only on registered state and SHALL NOT depend on in_valid.
REQ-018 A write and a read in the same cycle SHALL be allowed when the FIFO is full; occupancy is unchanged.
REQ-019 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 head_flit SHALL equal the FIFO head entry (storage slot at the read pointer) whenever the FIFO is non-empty.
REQ-021 The FSM SHALL have three states: IDLE, WAIT_GRANT, TRANSFER.
REQ-022 IDLE -> WAIT_GRANT SHALL occur when the FIFO is non-empty and the head flit type is HEAD or HEADTAIL; on that edge route_req_msg is latched into sw_port.
REQ-023 In IDLE, a BODY or TAIL flit at the head SHALL be dropped: it is popped in one cycle with out_valid low.
REQ-024 In WAIT_GRANT, sw_req SHALL be 1 and sw_port SHALL hold its value.
REQ-025 sw_grant in WAIT_GRANT SHALL move the FSM to TRANSFER on the next edge; sw_req stays high while the FSM is in TRANSFER.
REQ-026 In TRANSFER, out_flit SHALL equal head_flit, and out_valid SHALL be high whenever the FIFO is non-empty; a pop occurs when out_valid && out_ready.
REQ-027 Popping a TAIL or HEADTAIL flit in TRANSFER SHALL return the FSM to IDLE and drop sw_req on the same edge.
REQ-028 Minimum latency SHALL be: flit written at edge t, request at t+1, grant seen at t+1, first out_valid at t+2.
REQ-029 sw_grant SHALL be ignored outside WAIT_GRANT; out_ready SHALL be ignored when out_valid is low.

Reset
REQ-030 While rst_n is low: FIFO empty, pointers 0, FSM IDLE, sw_req 0, sw_port 0, out_valid 0, in_ready 0.
REQ-031 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-032 Reset asserted mid-packet SHALL discard all buffered flits and any packet in progress.

Structure
REQ-033 Flit-type encodings and the FSM state encoding SHALL live in a shared package/include (noc_defs) used by all router stages.
REQ-034 The buffer SHALL be a sub-module flit_fifo (params WIDTH, DEPTH), instantiated once.

Verification
REQ-035 Single HEADTAIL flit to dest 2, route_req_msg=2'b10, grant in the same cycle as the request -> sw_port=2'b10, one out_flit, FSM back to IDLE, sw_req low after the pop.
REQ-036 HEAD, 2 BODY, TAIL with out_ready=1 and grant delayed 3 cycles -> 4 flits out in order; sw_req high for exactly the cycles from the request through the TAIL pop.
REQ-037 FIFO_DEPTH=4 and out_ready=0, 6 flits offered -> in_ready drops after 4 accepted; simultaneous push/pop while full keeps the count at 4.
REQ-038 Stray BODY flit at the head in IDLE -> popped, out_valid never asserted, sw_req stays 0.
REQ-039 rst_n pulsed low after the 2nd flit of a 4-flit packet -> all outputs at reset values immediately; a following fresh packet routes correctly.
REQ-040 Back-to-back packets to ports 1 then 3 -> sw_port changes only after the first TAIL pop; no flit interleaving.
